vga_text_scanner: RTL

//  Read side of the text-mode display buffer. Generates 640x480@60 VGA timing
//  and scans the 64x48 char/color cell array (3072 cells, 10x10 px each) by

---
 rtl/vga_text_scanner_if.sv | 32 +++
 rtl/vga_text_scanner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_text_scanner_if.sv
// Buffer/font read ports and VGA pin bundle for the text-mode scanner.
// cursor_pos exists only when VGA_TEXT_CURSOR_EN is defined.
interface vga_text_scanner_if;
  logic [11:0] vga_addr;
  logic [7:0]  char_in;
  logic [7:0]  color_in;
  logic [10:0] font_addr;
  logic [7:0]  font_row;
`ifdef VGA_TEXT_CURSOR_EN
  logic [11:0] cursor_pos;
`endif
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_start;

  modport master (
    output vga_addr, font_addr, hsync, vsync, rgb, frame_start,
    input  char_in, color_in, font_row
`ifdef VGA_TEXT_CURSOR_EN
    , input cursor_pos
`endif
  );

  modport slave (
    input  vga_addr, font_addr, hsync, vsync, rgb, frame_start,
    output char_in, color_in, font_row
`ifdef VGA_TEXT_CURSOR_EN
    , output cursor_pos
`endif
  );
endinterface

// File: rtl/vga_text_scanner.sv
// 640x480 VGA text scanner: 64x48 cells of 10x10 px, 3-tick fetch pipeline.
// Define VGA_TEXT_CURSOR_EN for the blinking fg/bg-swap cursor.
module vga_text_scanner #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
`ifdef VGA_TEXT_CURSOR_EN
  , parameter int BLINK_FRAMES = 32
`endif
) (
  input logic clk,
  input logic reset,
  vga_text_scanner_if.master bus
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STAGES  = 3;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VEND   = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VEND   = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic          tick, wrap;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [3:0]    cx, cy;
  logic [5:0]    col, row;
  logic          vis, hs_n, vs_n, cur_hit;

  logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;
  logic [2:0]      grow1, bsel1, bsel2;
  logic            bord1, bord2, hit1, hit2;
  logic [7:0]      color2;
  logic [3:0]      fg_idx, bg_idx;
  logic            px_on;

  assign tick = (div == DIV_LAST);
  assign wrap = tick && (h == H_LAST) && (v == V_LAST);
  assign vis  = (h < H_VEND) && (v < V_VEND);
  assign hs_n = !((h >= HS_BEG) && (h <= HS_END));
  assign vs_n = !((v >= VS_BEG) && (v <= VS_END));

  assign bus.hsync = hs_pipe[STAGES];
  assign bus.vsync = vs_pipe[STAGES];

`ifdef VGA_TEXT_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Visible cells are always < 3072, the explicit bound keeps stale high values inert
  assign cur_hit = blink_on && vis && ({row, col} == bus.cursor_pos) &&
                   (bus.cursor_pos < 12'd3072);

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign cur_hit = 1'b0;
`endif

  // Beam position plus cell sub-counters; cells are 10 px so no divider needed
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h <= '0; v <= '0;
      cx <= '0; cy <= '0; col <= '0; row <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      bus.frame_start <= wrap;
      if (tick) begin
        if (h == H_LAST) begin
          h <= '0; cx <= '0; col <= '0;
          if (v == V_LAST) begin
            v <= '0; cy <= '0; row <= '0;
          end else begin
            v <= v + VW'(1);
            if (cy == 4'd9) begin
              cy  <= '0;
              row <= row + 6'd1;
            end else begin
              cy <= cy + 4'd1;
            end
          end
        end else begin
          h <= h + HW'(1);
          if (cx == 4'd9) begin
            cx  <= '0;
            col <= col + 6'd1;
          end else begin
            cx <= cx + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    fg_idx = hit2 ? color2[3:0] : color2[7:4];
    bg_idx = hit2 ? color2[7:4] : color2[3:0];
    px_on  = !bord2 && bus.font_row[bsel2];
  end

  function automatic logic [11:0] pal(input logic [3:0] idx);
    logic [3:0] on, off;
    on  = idx[3] ? 4'hF : 4'hA;
    off = idx[3] ? 4'h5 : 4'h0;
    return {idx[2] ? on : off, idx[1] ? on : off, idx[0] ? on : off};
  endfunction

  // S1 address, S2 char/color -> font address, S3 glyph bit -> rgb
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.vga_addr  <= '0;
      bus.font_addr <= '0;
      bus.rgb       <= '0;
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      grow1 <= '0; bsel1 <= '0; bsel2 <= '0;
      bord1 <= 1'b0; bord2 <= 1'b0;
      hit1  <= 1'b0; hit2  <= 1'b0;
      color2 <= '0;
    end else if (tick) begin
      bus.vga_addr <= vis ? {row, col} : 12'd0;
      vld_pipe <= {vld_pipe[STAGES-1:1], vis};
      hs_pipe  <= {hs_pipe[STAGES-1:1], hs_n};
      vs_pipe  <= {vs_pipe[STAGES-1:1], vs_n};
      // Glyph row is cy-1; bit index 8-cx taken mod 8 over cx[2:0]
      grow1 <= cy[2:0] - 3'd1;
      bsel1 <= 3'd0 - cx[2:0];
      bord1 <= (cx == 4'd0) || (cx == 4'd9) || (cy == 4'd0) || (cy == 4'd9);
      hit1  <= cur_hit;

      bus.font_addr <= {bus.char_in, grow1};
      color2 <= bus.color_in;
      bsel2  <= bsel1;
      bord2  <= bord1;
      hit2   <= hit1;

      bus.rgb <= vld_pipe[2] ? pal(px_on ? fg_idx : bg_idx) : 12'h000;
    end
  end
endmodule
